// File: rtl/prog_loader_pkg.sv
// Shared loader/CPU definitions: byte and instruction widths, loader FSM encoding
// and small decode helpers used by the loader top.
package prog_loader_pkg;

  localparam int BYTE_W  = 8;
  localparam int INSTR_W = 16;
  localparam int LEN_W   = 16;
  localparam int CNT_W   = LEN_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DAT_HI = 3'd3,
    ST_DAT_LO = 3'd4,
    ST_CHK    = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } ldr_state_e;

  // States in which a stream byte may be consumed.
  function automatic logic accepts_bytes(input ldr_state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DAT_HI) ||
           (s == ST_DAT_LO) || (s == ST_CHK);
  endfunction

  // A word count is usable when non-zero and no larger than the memory depth.
  function automatic logic len_valid(input logic [CNT_W-1:0] n, input int unsigned addr_w);
    logic [31:0] n_ext;
    n_ext = {{(32-CNT_W){1'b0}}, n};
    return (n_ext != 32'd0) && (n_ext <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/prog_loader_word_packer.sv
// Assembles big-endian instruction words from the byte stream and keeps the
// running XOR of every word byte for the trailing checksum.
module prog_loader_word_packer
  import prog_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               hi_we_i,
  input  logic               lo_we_i,
  input  logic [BYTE_W-1:0]  byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic [BYTE_W-1:0]  chk_o
);

  logic [BYTE_W-1:0]  hi_q, hi_d;
  logic [INSTR_W-1:0] word_q, word_d;
  logic [BYTE_W-1:0]  chk_q, chk_d;

  always_comb begin
    hi_d   = hi_q;
    word_d = word_q;
    chk_d  = chk_q;
    if (clear_i) begin
      chk_d = '0;
    end
    if (hi_we_i) begin
      hi_d  = byte_i;
      chk_d = chk_q ^ byte_i;
    end
    if (lo_we_i) begin
      word_d = {hi_q, byte_i};
      chk_d  = chk_q ^ byte_i;
    end
  end

  // The assembled word is deliberately not cleared on a new load so the
  // memory data bus keeps its last value between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      word_q <= '0;
      chk_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      word_q <= word_d;
      chk_q  <= chk_d;
    end
  end

  assign word_o = word_q;
  assign chk_o  = chk_q;

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a length-prefixed, XOR-checksummed byte
// stream into instruction-memory writes while holding the CPU.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter int          DATA_W    = INSTR_W,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  ldr_state_e        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [BYTE_W-1:0] len_hi_q, len_hi_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  idx_q, idx_d;

  logic               accept;
  logic               pk_clear, pk_hi_we, pk_lo_we;
  logic [INSTR_W-1:0] pk_word;
  logic [BYTE_W-1:0]  pk_chk;
  logic [CNT_W-1:0]   idx_inc;
  logic [CNT_W-1:0]   len_new;

  assign accept  = in_valid & in_ready_q;
  assign idx_inc = idx_q + CNT_W'(1);
  assign len_new = {1'b0, len_hi_q, in_data};

  always_comb begin
    state_d    = state_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    err_d      = err_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    idx_d      = idx_q;
    pk_clear   = 1'b0;
    pk_hi_we   = 1'b0;
    pk_lo_we   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN_HI;
          idx_d      = '0;
          pk_clear   = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          cpu_hold_d = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_hi_d = in_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d = len_new;
          if (len_valid(len_new, ADDR_W)) begin
            state_d = ST_DAT_HI;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      ST_DAT_HI: begin
        if (accept) begin
          pk_hi_we = 1'b1;
          state_d  = ST_DAT_LO;
        end
      end
      ST_DAT_LO: begin
        // The write strobe, address and packed word all appear on the next cycle.
        if (accept) begin
          pk_lo_we   = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = BASE + idx_q[ADDR_W-1:0];
          idx_d      = idx_inc;
          state_d    = (idx_inc == len_q) ? ST_CHK : ST_DAT_HI;
        end
      end
      ST_CHK: begin
        if (accept) begin
          if (in_data == pk_chk) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = accepts_bytes(state_d);
  end

  // Reset wins over start and over any byte accepted on the same edge, which
  // also drops a write that would otherwise have been strobed next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= BASE;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      len_hi_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
    end
  end

  prog_loader_word_packer u_word_packer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (pk_clear),
    .hi_we_i (pk_hi_we),
    .lo_we_i (pk_lo_we),
    .byte_i  (in_data),
    .word_o  (pk_word),
    .chk_o   (pk_chk)
  );

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = DATA_W'(pk_word);
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
